// File: rtl/trng_ctrl.sv
// TRNG controller: sequences a ring generator, packs sampled bits into
// 32-bit words and stops on a repetition-count health failure.
module trng_ctrl #(
   parameter int unsigned WARMUP_CYCLES = 64,
   parameter int unsigned SAMPLE_DIV    = 4,
   parameter int unsigned REP_LIMIT     = 32
) (
   input  logic        iClk,
   input  logic        iRstn,
   input  logic        iStart,
   input  logic        iStop,
   input  logic        iClrFail,
   input  logic        iSerial,
   output logic        oRgEn,
   output logic        oRgRst,
   output logic [31:0] oData,
   output logic        oValid,
   input  logic        iReady,
   output logic        oBusy,
   output logic        oFail
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL
   } state_t;

   localparam logic [15:0] LP_WARM_LAST = 16'(WARMUP_CYCLES - 1);
   localparam logic [7:0]  LP_DIV_LAST  = 8'(SAMPLE_DIV - 1);
   localparam logic [7:0]  LP_REP_LIM   = 8'(REP_LIMIT);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_warm;
   logic [7:0]  r_div;
   logic [5:0]  r_bits;
   logic [7:0]  r_rep;
   logic        r_prev;
   logic [31:0] r_word;
   logic [31:0] r_data;

   logic        w_sample;
   logic        w_done;
   logic        w_rep_hit;
   logic [7:0]  w_rep_next;
   logic [31:0] w_shift;

   assign w_sample  = (r_state == S_COLLECT) && (r_div == LP_DIV_LAST);
   assign w_done    = w_sample && (r_bits == 6'd31);
   assign w_shift   = {r_word[30:0], iSerial};
   // r_rep == 0 means no previous sample since CLEAR
   assign w_rep_next = (r_rep != 8'd0 && iSerial == r_prev) ?
                       ((r_rep == 8'hFF) ? r_rep : r_rep + 8'd1) : 8'd1;
   assign w_rep_hit = w_sample && (w_rep_next == LP_REP_LIM);

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (iStart) w_next = S_CLEAR;
         S_CLEAR:   w_next = iStop ? S_IDLE : S_WARMUP;
         S_WARMUP: begin
            if (iStop)                     w_next = S_IDLE;
            else if (r_warm == LP_WARM_LAST) w_next = S_COLLECT;
         end
         S_COLLECT: begin
            if (w_rep_hit)   w_next = S_FAIL;
            else if (iStop)  w_next = S_IDLE;
            else if (w_done) w_next = S_HOLD;
         end
         S_HOLD: begin
            if (iStop)       w_next = S_IDLE;
            else if (iReady) w_next = S_COLLECT;
         end
         S_FAIL:    if (iClrFail) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         r_warm <= '0;
         r_div  <= '0;
         r_bits <= '0;
         r_rep  <= '0;
         r_prev <= 1'b0;
         r_word <= '0;
         r_data <= '0;
      end else if (r_state == S_CLEAR) begin
         r_warm <= '0;
         r_div  <= '0;
         r_bits <= '0;
         r_rep  <= '0;
         r_prev <= 1'b0;
         r_word <= '0;
      end else if (r_state == S_WARMUP) begin
         r_warm <= r_warm + 16'd1;
      end else if (r_state == S_COLLECT) begin
         if (w_sample) begin
            r_div  <= '0;
            r_bits <= r_bits + 6'd1;
            r_word <= w_shift;
            r_rep  <= w_rep_next;
            r_prev <= iSerial;
            if (w_done && !w_rep_hit && !iStop) r_data <= w_shift;
         end else begin
            r_div <= r_div + 8'd1;
         end
      end else if (r_state == S_HOLD && iReady) begin
         r_div  <= '0;
         r_bits <= '0;
      end
   end

   assign oData  = r_data;
   assign oValid = (r_state == S_HOLD);
   assign oFail  = (r_state == S_FAIL);
   assign oRgRst = (r_state == S_IDLE) || (r_state == S_CLEAR) ||
                   (r_state == S_FAIL);
   assign oRgEn  = (r_state == S_WARMUP) || (r_state == S_COLLECT) ||
                   (r_state == S_HOLD);
   assign oBusy  = !((r_state == S_IDLE) || (r_state == S_FAIL));

endmodule
